// File: rtl/alu_ctrl_decoder_pipe.sv
// ALU control decoder: a writable opcode decode table feeding a STAGES-deep valid/ready pipeline.
// Define ALU_CTRL_PARITY_EN to add per-entry even parity, a sticky parity_err and tbl_perr_inj.
module alu_ctrl_decoder_pipe #(
  parameter int OP_W   = 4,
  parameter int LS_W   = 4,
  parameter int STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [OP_W-1:0]   in_aluop,
  output logic              in_ready,
  input  logic              out_ready,
  input  logic              flush,
  input  logic              tbl_we,
  input  logic [OP_W-1:0]   tbl_addr,
  input  logic [LS_W+3:0]   tbl_wdata,
`ifdef ALU_CTRL_PARITY_EN
  input  logic              tbl_perr_inj,
  output logic              parity_err,
`endif
  output logic              out_valid,
  output logic [LS_W-1:0]   LogicSelect,
  output logic              ShiftSelectA,
  output logic              ShiftSelectB,
  output logic              CarrySelectA,
  output logic              CarrySelectB
);

  localparam int DATA_W = LS_W + 4;
  localparam int DEPTH  = 1 << OP_W;
`ifdef ALU_CTRL_PARITY_EN
  localparam int TBL_W  = DATA_W + 1;
`else
  localparam int TBL_W  = DATA_W;
`endif

  logic [TBL_W-1:0]  table_q [DEPTH];
  logic [TBL_W-1:0]  wr_word;
  logic [TBL_W-1:0]  rd_word;
  logic [STAGES-1:0] valid_q;
  logic [DATA_W-1:0] data_q [STAGES];
  logic [DATA_W-1:0] out_word;
  logic              adv;
  logic              accept;

  // The pipeline only stalls when the last stage holds a result nobody takes.
  assign out_valid = valid_q[STAGES-1];
  assign adv       = out_ready | ~out_valid;
  assign in_ready  = adv & ~flush;
  assign accept    = in_valid & in_ready;

`ifdef ALU_CTRL_PARITY_EN
  // Stored parity makes the XOR over the whole entry zero; injection flips it.
  assign wr_word = {(^tbl_wdata) ^ tbl_perr_inj, tbl_wdata};
`else
  assign wr_word = tbl_wdata;
`endif

  // Write-through: a lookup colliding with a write sees the new entry.
  assign rd_word = (tbl_we && (tbl_addr == in_aluop)) ? wr_word : table_q[in_aluop];

  // NOTE: the table must come up all-zero, so it is built from resettable flops,
  // not a RAM macro; a reset loop over the array is the intended structure here.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
    end else if (tbl_we) begin
      table_q[tbl_addr] <= wr_word;
    end
  end

  // NOTE: every stage is updated with non-blocking assignments so each one
  // captures its predecessor's pre-edge value and the shift is order-independent.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int i = 0; i < STAGES; i++) data_q[i] <= '0;
    end else if (flush) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= accept;
      data_q[0]  <= rd_word[DATA_W-1:0];
      for (int i = 1; i < STAGES; i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
      end
    end
  end

`ifdef ALU_CTRL_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      parity_err <= 1'b0;
    end else if (accept && (^rd_word)) begin
      parity_err <= 1'b1;
    end
  end
`endif

  // Stale stage data stays in the registers after a flush; gating hides it.
  assign out_word = out_valid ? data_q[STAGES-1] : '0;
  assign {LogicSelect, ShiftSelectA, ShiftSelectB, CarrySelectA, CarrySelectB} = out_word;

endmodule

// File: tb/tb_alu_ctrl_decoder_pipe.sv
// Scoreboard bench for alu_ctrl_decoder_pipe: directed scenarios plus a constrained-random phase.
module tb_alu_ctrl_decoder_pipe;

  localparam int OP_W   = 4;
  localparam int LS_W   = 4;
  localparam int STAGES = 2;
  localparam int DW     = LS_W + 4;

  typedef struct {
    logic [DW-1:0] data;
    int            acc_cycle;
    int            acc_stalls;
  } sb_entry_t;

  logic            clk = 1'b0;
  logic            rst_n, in_valid, in_ready, out_ready, flush, tbl_we, out_valid;
  logic [OP_W-1:0] in_aluop, tbl_addr;
  logic [DW-1:0]   tbl_wdata;
  logic [LS_W-1:0] LogicSelect;
  logic            ShiftSelectA, ShiftSelectB, CarrySelectA, CarrySelectB;
  logic [DW-1:0]   out_word;
`ifdef ALU_CTRL_PARITY_EN
  logic            tbl_perr_inj, parity_err;
`endif

  int            checks = 0;
  int            errors = 0;
  int            cycle = 0;
  int            stall_count = 0;
  sb_entry_t     sb_q[$];
  logic [DW-1:0] model_tbl [1 << OP_W];
  logic          prev_stall = 1'b0;
  logic [DW-1:0] prev_word = '0;

  always #5 clk = ~clk;

  alu_ctrl_decoder_pipe #(.OP_W(OP_W), .LS_W(LS_W), .STAGES(STAGES)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_aluop(in_aluop), .in_ready(in_ready),
    .out_ready(out_ready), .flush(flush), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata),
`ifdef ALU_CTRL_PARITY_EN
    .tbl_perr_inj(tbl_perr_inj), .parity_err(parity_err),
`endif
    .out_valid(out_valid), .LogicSelect(LogicSelect), .ShiftSelectA(ShiftSelectA),
    .ShiftSelectB(ShiftSelectB), .CarrySelectA(CarrySelectA), .CarrySelectB(CarrySelectB)
  );

  assign out_word = {LogicSelect, ShiftSelectA, ShiftSelectB, CarrySelectA, CarrySelectB};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cycle);
    end
  endtask

  // Inputs are already driven; score this cycle, then cross one rising edge.
  task automatic tick();
    logic      exp_rdy;
    sb_entry_t e;
    #1;
    if (!rst_n) begin
      sb_q.delete();
      for (int i = 0; i < (1 << OP_W); i++) model_tbl[i] = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("stall_valid", 32'(out_valid), 32'(1));
        check("stall_hold", 32'(out_word), 32'(prev_word));
      end
      if (!out_valid) check("gate", 32'(out_word), 32'(0));
      exp_rdy = (out_ready | ~out_valid) & ~flush;
      check("in_ready", 32'(in_ready), 32'(exp_rdy));
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          check("unexpected_out", 32'(out_valid), 32'(0));
        end else begin
          e = sb_q.pop_front();
          check("out_data", 32'(out_word), 32'(e.data));
          if (e.acc_stalls == stall_count)
            check("latency", 32'(cycle - e.acc_cycle), 32'(STAGES));
        end
      end
      if (flush) begin
        sb_q.delete();
      end else if (in_valid && exp_rdy) begin
        e.data       = (tbl_we && tbl_addr == in_aluop) ? tbl_wdata : model_tbl[in_aluop];
        e.acc_cycle  = cycle;
        e.acc_stalls = stall_count;
        sb_q.push_back(e);
      end
      if (tbl_we) model_tbl[tbl_addr] = tbl_wdata;
      prev_stall = out_valid & ~out_ready & ~flush;
      if (prev_stall) stall_count++;
      prev_word = out_word;
    end
    @(posedge clk);
    @(negedge clk);
    cycle++;
  endtask

  task automatic issue(input logic [OP_W-1:0] op);
    in_valid = 1'b1;
    in_aluop = op;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic write_tbl(input logic [OP_W-1:0] addr, input logic [DW-1:0] data);
    tbl_we    = 1'b1;
    tbl_addr  = addr;
    tbl_wdata = data;
    tick();
    tbl_we = 1'b0;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int k = 0; k < 40 && sb_q.size() != 0; k++) tick();
    tick();
    check("drain", 32'(sb_q.size()), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_aluop = '0; out_ready = 1'b1; flush = 1'b0;
    tbl_we = 1'b0; tbl_addr = '0; tbl_wdata = '0;
`ifdef ALU_CTRL_PARITY_EN
    tbl_perr_inj = 1'b0;
`endif
    @(negedge clk);
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_valid", 32'(out_valid), 32'(0));
    check("rst_outputs", 32'(out_word), 32'(0));

    // Lookup in an empty table.
    issue(4'h3);
    check("lat_not_yet", 32'(out_valid), 32'(STAGES == 1));
    tick();
    check("empty_valid", 32'(out_valid), 32'(1));
    check("empty_word", 32'(out_word), 32'(0));
    drain();

    // Program one entry and check each field.
    write_tbl(4'h5, 8'b1010_1001);
    issue(4'h5);
    tick();
    check("ls", 32'(LogicSelect), 32'(4'b1010));
    check("ssa", 32'(ShiftSelectA), 32'(1));
    check("ssb", 32'(ShiftSelectB), 32'(0));
    check("csa", 32'(CarrySelectA), 32'(0));
    check("csb", 32'(CarrySelectB), 32'(1));
    drain();

    // Back-to-back lookups with entry = address.
    for (int i = 0; i < 16; i++) write_tbl(OP_W'(i), DW'(i));
    for (int i = 0; i < 16; i++) begin
      in_valid = 1'b1;
      in_aluop = OP_W'(i);
      tick();
    end
    in_valid = 1'b0;
    drain();

    // Stall with two entries in flight; an offered op must wait.
    issue(4'h1);
    issue(4'h2);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_aluop  = 4'h9;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_in_ready", 32'(in_ready), 32'(0));
      check("stall_word", 32'(out_word), 32'(8'h01));
    end
    in_valid = 1'b0;
    drain();

    // Write/lookup collision returns the written entry.
    tbl_we = 1'b1; tbl_addr = 4'h7; tbl_wdata = 8'hFF;
    issue(4'h7);
    tbl_we = 1'b0;
    tick();
    check("collide_word", 32'(out_word), 32'(8'hFF));
    drain();

    // Flush beats a stall and drops the same-cycle input.
    issue(4'h5);
    issue(4'h7);
    flush = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_aluop = 4'h3;
    tick();
    flush = 1'b0; out_ready = 1'b1; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'(0));
    check("flush_word", 32'(out_word), 32'(0));
    tick();
    tick();
    drain();

    // Constrained-random traffic.
    for (int i = 0; i < 120; i++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_aluop  = OP_W'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tbl_we    = ($urandom_range(0, 4) == 0);
      tbl_addr  = OP_W'($urandom);
      tbl_wdata = DW'($urandom);
      flush     = ($urandom_range(0, 19) == 0);
      tick();
    end
    in_valid = 1'b0; tbl_we = 1'b0; flush = 1'b0;
    drain();

    // Reset mid-operation clears the pipeline and the table.
    issue(4'h5);
    issue(4'h6);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_valid", 32'(out_valid), 32'(0));
    issue(4'h7);
    tick();
    check("midrst_tbl", 32'(out_word), 32'(0));
    drain();

`ifdef ALU_CTRL_PARITY_EN
    check("par_clean", 32'(parity_err), 32'(0));
    tbl_perr_inj = 1'b1;
    write_tbl(4'h2, 8'h5A);
    tbl_perr_inj = 1'b0;
    check("par_before", 32'(parity_err), 32'(0));
    issue(4'h2);
    check("par_set", 32'(parity_err), 32'(1));
    for (int i = 0; i < 4; i++) tick();
    check("par_sticky", 32'(parity_err), 32'(1));
    drain();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("par_reset", 32'(parity_err), 32'(0));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_ctrl_decoder_pipe.md
Name: alu_ctrl_decoder_pipe

Overview:
Programmable, pipelined successor to the fixed ALU diode matrix. It decodes an ALU opcode into logic-select, shift-select and carry-select control lines through a writable decode table, then carries the result through STAGES register stages. Flow control is valid/ready with stall and flush. It sits between the instruction decode stage and the ALU datapath in the JAM-1 pipeline.

Parameters:
OP_W, 4, opcode width; table depth is 2**OP_W entries
LS_W, 4, LogicSelect width (logic-unit truth-table bits)
STAGES, 2, pipeline depth in cycles, legal range 1..4; total latency equals STAGES

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  synchronous active-low reset
in_valid  in  1  opcode presented
in_aluop  in  OP_W  opcode
in_ready  out  1  block accepts the opcode this cycle
out_ready  in  1  downstream accepts the output this cycle
flush  in  1  discard all in-flight entries
tbl_we  in  1  decode-table write strobe
tbl_addr  in  OP_W  table write address
tbl_wdata  in  LS_W+4  entry {LogicSelect, SSA, SSB, CSA, CSB}, MSB first
out_valid  out  1  output entry valid
LogicSelect  out  LS_W  decoded logic select
ShiftSelectA  out  1  shift select A
ShiftSelectB  out  1  shift select B
CarrySelectA  out  1  carry select A
CarrySelectB  out  1  carry select B

Behaviour:
- One clock domain. Reset is synchronous and active-low: it is sampled on the rising edge of clk while rst_n=0.
- Reset: all table entries = 0, all stage valid bits = 0, all stage data = 0. out_valid=0 and all control outputs = 0.
- Pipeline advance: adv = out_ready | ~out_valid. When adv=1, every stage shifts forward one position. When adv=0, all stages hold. in_ready = adv & ~flush.
- Stage 1 latches valid = in_valid & in_ready and data = table[in_aluop], a registered read. Stages 2..STAGES are plain registers.
- Latency: an opcode accepted at edge N appears on the outputs after edge N+STAGES-1, i.e. during cycle N+STAGES-1 when there are no stalls.
- Output gating: when out_valid=0, LogicSelect and the four select outputs are driven to 0.
- Table write: on tbl_we=1, table[tbl_addr] <= tbl_wdata at the clock edge. A write is never blocked by stall or flush.
- Write/lookup collision: an accepted lookup to the same address in the same cycle as a write returns tbl_wdata (write-through). Entries already in the pipeline are not affected.
- Flush: on the next edge, all stage valid bits are cleared. Stage data holds its value but is gated off at the outputs. An in_valid presented in the same cycle is dropped, since in_ready=0. Flush takes priority over stall.
- Stall: while out_valid=1 and out_ready=0, all outputs hold stable and no entry is lost or duplicated. Bubbles are not collapsed.
- rst_n=0 mid-operation: reset overrides everything, including the table contents.

Optional Feature:
ALU_CTRL_PARITY_EN
- Macro defined:
  - Each table entry stores an extra even-parity bit, computed on write.
  - Stage 1 checks parity on every accepted lookup.
  - A mismatch sets a sticky output port parity_err (1 bit), which is cleared only by reset.
  - A debug-only input tbl_perr_inj (1 bit) inverts the stored parity bit on a write.
  - parity_err resets to 0.
- Macro undefined: parity_err and tbl_perr_inj do not exist, and the table is LS_W+4 bits wide.

Test Plan:
- Reset then lookup: rst_n=0 for 2 cycles, then in_aluop=4'h3 with in_valid=1 → after STAGES=2 cycles, out_valid=1 and all outputs=0 (empty table).
- Program and lookup: write table[4'h5]=8'b1010_1001, then issue op 5 → exactly 2 cycles later LogicSelect=4'b1010, SSA=1, SSB=0, CSA=0, CSB=1.
- Back-to-back ops 0..15 with out_ready=1 after the table is loaded with entry=address → one result per cycle, in order, first result at cycle 2.
- Stall: hold out_ready=0 for 5 cycles with 2 entries in flight → outputs stable, in_ready=0, both entries emerge in order after release, none lost or duplicated.
- Collision and flush: write table[7]=8'hFF while looking up op 7 → output 8'hFF. Assert flush with 2 entries in flight → out_valid=0 on the next cycle and outputs=0.
- With ALU_CTRL_PARITY_EN: write entry 2 with tbl_perr_inj=1, then look up op 2 → parity_err=1 and stays set until rst_n=0.
